uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmit path among NumReq requesters. The transmit path is the TX FIFO write port: data, request strobe and ready.
- Grants are message-level round-robin. The grant is held until the owner marks its last byte, reaches the burst limit, or stalls past a timeout.
- Sits between software/protocol requesters and the `uart` top-level `i_tx_data` / `i_tx_req` / `o_tx_rdy` ports.

Parameters:
- NumReq, 4, number of requesters (>=2).
- DataLength, 8, byte width; matches `uart` DataLength.
- MaxBurst, 4, maximum bytes per grant before forced release (>=1).
- IdleTimeout, 16, consecutive owner-idle cycles before forced release (>=2).

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req  input  NumReq  per-requester "byte valid".
- i_last  input  NumReq  per-requester "this byte ends the message"; qualified by i_req.
- i_data  input  NumReq*DataLength  flattened byte bus; requester k occupies bits [k*DataLength +: DataLength].
- o_ack  output  NumReq  one-hot transfer-accepted strobe to the owner.
- o_tx_data  output  DataLength  byte to the UART TX FIFO.
- o_tx_req  output  1  write strobe to the UART TX FIFO.
- i_tx_rdy  input  1  UART TX FIFO not full.
- o_owner  output  $clog2(NumReq)  current owner index.
- o_busy  output  1  a grant is held.
- o_timeout  output  1  one-cycle pulse on idle-timeout release.

Behaviour:
- Reset, asynchronous on i_rst_n low:
  - state=ARB; rr_ptr=0; owner=0; burst_cnt=0; idle_cnt=0.
  - Outputs: o_ack=0, o_tx_req=0, o_tx_data=0, o_owner=0, o_busy=0, o_timeout=0.
  - A reset mid-message drops the grant silently; no partial-message recovery.
- State ARB, o_busy=0:
  - If |i_req, select the first asserted requester scanning from rr_ptr upward, wrapping modulo NumReq.
  - Registered: owner<=sel, burst_cnt<=0, idle_cnt<=0, state<=OWN.
  - The grant is effective the next cycle, so arbitration latency is 1 cycle. No transfer can occur in ARB.
- State OWN, o_busy=1:
  - xfer = i_req[owner] & i_tx_rdy. This is combinational.
  - o_tx_req = xfer; o_ack = xfer ? (1<<owner) : 0.
  - o_tx_data = i_data slice of owner while in OWN, otherwise 0.
  - On xfer:
    - idle_cnt<=0.
    - If i_last[owner] or burst_cnt==MaxBurst-1: release, i.e. state<=ARB and rr_ptr<=(owner+1) mod NumReq.
    - Otherwise burst_cnt<=burst_cnt+1.
  - On no xfer because i_req[owner]=0:
    - idle_cnt<=idle_cnt+1.
    - At idle_cnt==IdleTimeout-1: release with rr_ptr<=owner+1, and o_timeout registered high for exactly 1 cycle.
  - On no xfer because i_tx_rdy=0 while i_req[owner]=1: hold. idle_cnt does not advance; backpressure never times out.
- Throughput: at most MaxBurst bytes per grant, then a mandatory 1-cycle ARB bubble.
- Fairness: a requester waits at most NumReq-1 grants.
- Boundary conditions:
  - Release and a new request on the same cycle: the request is arbitrated in the following ARB cycle, never granted combinationally.
  - Wrap: rr_ptr==NumReq-1 plus release gives rr_ptr=0.
  - Non-owner i_req/i_last are ignored during OWN.
  - i_last and the burst limit on the same transfer: a single release, no double-increment of rr_ptr.
  - Counter widths: burst_cnt is $clog2(MaxBurst+1) bits; idle_cnt is $clog2(IdleTimeout+1) bits; neither ever wraps.

Decomposition:
- uart_pkg: arb_state_e {ARB, OWN}, plus a helper function returning the counter width as $clog2(x+1).
- Sub-module rr_pick: purely combinational round-robin priority select.
  - Inputs: req vector and rr_ptr.
  - Outputs: sel index and any_req.
  - Implemented by rotate, then find-first-set, then un-rotate.

Test Plan (NumReq=4, MaxBurst=4, IdleTimeout=16, i_tx_rdy=1 unless stated):
- Single requester: req[2] sends 0xA5, 0x3C, 0x7E with last on 0x7E.
  - Response: o_tx_req pulses 3 cycles with those bytes in order and o_ack=4'b0100 each time.
  - Then o_busy falls; rr_ptr=3.
- Contention: req[0..3] all held, each sending 6-byte messages.
  - Response: grant order 0,1,2,3,0…; each grant ends after exactly 4 bytes.
  - One idle cycle appears between grants.
- Backpressure: owner 1 mid-message, i_tx_rdy=0 for 40 cycles.
  - Response: no o_tx_req, no timeout, grant held; transfer resumes when i_tx_rdy returns.
- Idle timeout: owner 3 sends one byte without last, then drops req.
  - Response: release 16 cycles later with o_timeout high exactly 1 cycle.
  - Next grant goes to 0 if req[0] is asserted.
- Reset mid-grant: assert i_rst_n=0 asynchronously during OWN.
  - Response: all outputs 0 immediately, without waiting for a clock.
  - After release of reset, the first grant goes to the lowest-indexed active requester.
- End-to-end with `uart`: 8 random bytes across 2 requesters. The serial stream on o_tx must match the ack order byte-for-byte, with valid stop bits.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART TX arbiter: FSM state enum and
// a counter-width helper ($clog2(x+1) bits hold 0..x).
package uart_pkg;

  typedef enum logic {
    ARB = 1'b0,
    OWN = 1'b1
  } arb_state_e;

  function automatic int cnt_w(input int x);
    return $clog2(x + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: rotate req by ptr_i,
// find first set, un-rotate. Ports: req_i, ptr_i -> sel_o, any_o.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] sel_o,
  output logic          any_o
);

  logic [N-1:0]  rot;
  logic [IW-1:0] off;

  function automatic logic [IW-1:0] wrap(
    input logic [IW-1:0] a,
    input int            b
  );
    int s;
    s = int'(a) + b;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req_i[wrap(ptr_i, i)];
    end
  end

  // Descending scan so the lowest rotated index wins.
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
  end

  assign any_o = |rot;
  assign sel_o = wrap(ptr_i, int'(off));

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-level round-robin arbiter sharing one UART TX FIFO write port.
// Ports: i_req/i_last/i_data per requester -> o_tx_*; o_ack, o_owner, o_busy, o_timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NumReq      = 4,
  parameter int DataLength  = 8,
  parameter int MaxBurst    = 4,
  parameter int IdleTimeout = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NumReq-1:0]            i_req,
  input  logic [NumReq-1:0]            i_last,
  input  logic [NumReq*DataLength-1:0] i_data,
  output logic [NumReq-1:0]            o_ack,
  output logic [DataLength-1:0]        o_tx_data,
  output logic                         o_tx_req,
  input  logic                         i_tx_rdy,
  output logic [$clog2(NumReq)-1:0]    o_owner,
  output logic                         o_busy,
  output logic                         o_timeout
);

  localparam int IW = $clog2(NumReq);
  localparam int BW = cnt_w(MaxBurst);
  localparam int TW = cnt_w(IdleTimeout);

  localparam logic [BW-1:0] BurstLast = BW'(MaxBurst - 1);
  localparam logic [TW-1:0] IdleLast  = TW'(IdleTimeout - 1);
  localparam logic [IW-1:0] OwnerMax  = IW'(NumReq - 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          tout_q, tout_d;

  logic [IW-1:0] sel;
  logic          any_req;
  logic          own_req;
  logic          own_last;
  logic          xfer;
  logic [IW-1:0] next_ptr;

  rr_pick #(
    .N  (NumReq),
    .IW (IW)
  ) u_pick (
    .req_i (i_req),
    .ptr_i (rr_q),
    .sel_o (sel),
    .any_o (any_req)
  );

  assign own_req  = i_req[owner_q];
  assign own_last = i_last[owner_q];
  assign xfer     = (state_q == OWN) & own_req & i_tx_rdy;
  assign next_ptr = (owner_q == OwnerMax) ? '0 : owner_q + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ARB;
      rr_q    <= '0;
      owner_q <= '0;
      burst_q <= '0;
      idle_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
      idle_q  <= idle_d;
      tout_q  <= tout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    burst_d = burst_q;
    idle_d  = idle_q;
    tout_d  = 1'b0;
    unique case (state_q)
      ARB: begin
        if (any_req) begin
          owner_d = sel;
          burst_d = '0;
          idle_d  = '0;
          state_d = OWN;
        end
      end
      OWN: begin
        // Backpressure (owner valid, FIFO full) falls to default: hold.
        unique case (1'b1)
          xfer: begin
            idle_d = '0;
            if (own_last || burst_q == BurstLast) begin
              state_d = ARB;
              rr_d    = next_ptr;
            end else begin
              burst_d = burst_q + 1'b1;
            end
          end
          !own_req: begin
            if (idle_q == IdleLast) begin
              state_d = ARB;
              rr_d    = next_ptr;
              tout_d  = 1'b1;
            end else begin
              idle_d = idle_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    o_tx_req  = 1'b0;
    o_ack     = '0;
    o_tx_data = '0;
    if (state_q == OWN) begin
      o_tx_data = i_data[owner_q*DataLength +: DataLength];
      o_tx_req  = xfer;
      if (xfer) o_ack[owner_q] = 1'b1;
    end
  end

  assign o_owner   = owner_q;
  assign o_busy    = (state_q == OWN);
  assign o_timeout = tout_q;

endmodule
